// File: rtl/mod_reducer.sv
// mod_reducer: computes x mod p by restoring shift-subtract, one dividend bit per
// clock (MSB first), returning the remainder and a divide-by-zero flag.
module mod_reducer #(
    parameter int XW = 64,
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x,
    input  logic [PW-1:0] p,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] r,
    output logic          err,
    output logic [1:0]    dbg_state
);
    // Handshake: start is taken only while idle (busy low), and x/p are captured on
    // that edge. done pulses for one cycle when r/err are updated; r/err then hold
    // until the next done. Start seen while busy is dropped, not queued.

    localparam int            CW      = (XW > 1) ? $clog2(XW) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(XW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [XW-1:0] r_x;
    logic [PW-1:0] r_p;
    logic [PW:0]   r_rem;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_res;
    logic          r_err;

    logic          w_accept;
    logic          w_last;
    logic [PW:0]   w_shift;
    logic [PW:0]   w_p_ext;
    logic          w_ge;
    logic [PW:0]   w_rem_next;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == '0);

    // The remainder is one bit wider than p so 2*rem+1 (< 2p) never overflows.
    assign w_shift    = {r_rem[PW-1:0], r_x[r_cnt]};
    assign w_p_ext    = {1'b0, r_p};
    assign w_ge       = (w_shift >= w_p_ext);
    assign w_rem_next = w_ge ? (w_shift - w_p_ext) : w_shift;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (p == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x   <= '0;
            r_p   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_x   <= x;
            r_p   <= p;
            r_rem <= '0;
            r_cnt <= CNT_TOP;
            // A zero modulus skips RUN and reports immediately.
            if (p == '0) begin
                r_res <= '0;
                r_err <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_res <= w_rem_next[PW-1:0];
                r_err <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign r         = r_res;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mod_reducer.sv
// Bench for mod_reducer: cycle-level reference model with a per-cycle compare on the
// 64/32 build, directed literal cases, randomized requests, and a 16/8 build.
module tb_mod_reducer;
    localparam int XW = 64;
    localparam int PW = 32;
    localparam int XS = 16;
    localparam int PS = 8;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, err;
    logic [XW-1:0] x;
    logic [PW-1:0] p, r;
    logic [1:0]    dbg_state;

    logic          s_rst, s_start, s_busy, s_done, s_err;
    logic [XS-1:0] s_x;
    logic [PS-1:0] s_p, s_r;
    logic [1:0]    s_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit fin16    = 1'b0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mod_reducer #(.XW(XW), .PW(PW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .p(p),
        .busy(busy), .done(done), .r(r), .err(err), .dbg_state(dbg_state)
    );

    mod_reducer #(.XW(XS), .PW(PS)) u_dut16 (
        .clk(clk), .rst(s_rst), .start(s_start), .x(s_x), .p(s_p),
        .busy(s_busy), .done(s_done), .r(s_r), .err(s_err), .dbg_state(s_dbg_state)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a request is an interval of edges; results appear at its end.
    int            cyc         = 0;
    bit            m_active    = 1'b0;
    int            m_done_edge = -10;
    logic [PW-1:0] m_r         = '0;
    logic [PW-1:0] m_next_r    = '0;
    logic          m_err       = 1'b0;
    logic          m_next_err  = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_active = 1'b0;
            m_r      = '0;
            m_err    = 1'b0;
        end else if (m_active) begin
            if (cyc == m_done_edge + 1) m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            if (p == '0) begin
                m_done_edge = cyc;
                m_next_r    = '0;
                m_next_err  = 1'b1;
            end else begin
                m_done_edge = cyc + XW;
                m_next_r    = PW'(x % {32'b0, p});
                m_next_err  = 1'b0;
            end
        end
        if (rst && m_active && cyc == m_done_edge) begin
            m_r   = m_next_r;
            m_err = m_next_err;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", busy, m_active);
            chk("cyc_done", done, m_active && (cyc == m_done_edge));
            chk("cyc_r", r, m_r);
            chk("cyc_err", err, m_err);
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic req(input logic [XW-1:0] xv, input logic [PW-1:0] pv,
                       input logic [PW-1:0] er, input logic ee, input int elat,
                       input string tag, input int poke);
        int lat;
        start = 1'b1;
        x     = xv;
        p     = pv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x     = {$urandom, $urandom};
        p     = $urandom;
        lat   = 1;
        while (done !== 1'b1 && lat < XW + 20) begin
            if (poke != 0 && lat == poke) begin
                start = 1'b1;
                x     = 1000;
                p     = 7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_r"}, r, er);
        chk({tag, "_err"}, err, ee);
        @(negedge clk);
        if (poke != 0) chk({tag, "_single_done"}, done, 1'b0);
    endtask

    task automatic req_rand();
        logic [XW-1:0] xv;
        logic [PW-1:0] pv;
        int            sel;
        sel = $urandom_range(0, 7);
        xv  = ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 300)) : {$urandom, $urandom};
        if (sel == 0)      pv = '0;
        else if (sel == 1) pv = PW'($urandom_range(1, 20));
        else               pv = $urandom;
        if (pv == '0) req(xv, pv, '0, 1'b1, 1, "rand_p0", 0);
        else          req(xv, pv, PW'(xv % {32'b0, pv}), 1'b0, XW + 1, "rand", 0);
    endtask

    task automatic req16(input logic [XS-1:0] xv, input logic [PS-1:0] pv);
        logic [PS-1:0] er;
        logic          ee;
        int            el, lat;
        if (pv == '0) begin
            er = '0; ee = 1'b1; el = 1;
        end else begin
            er = PS'(xv % {8'b0, pv}); ee = 1'b0; el = XS + 1;
        end
        s_start = 1'b1;
        s_x     = xv;
        s_p     = pv;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        s_x     = XS'($urandom);
        s_p     = PS'($urandom);
        lat     = 1;
        while (s_done !== 1'b1 && lat < XS + 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w16_done", s_done, 1'b1);
        chk("w16_lat", lat, el);
        chk("w16_r", s_r, er);
        chk("w16_err", s_err, ee);
        @(negedge clk);
        chk("w16_idle_busy", s_busy, 1'b0);
    endtask

    initial begin
        s_rst = 1'b0; s_start = 1'b0; s_x = '0; s_p = '0;
        repeat (3) @(negedge clk);
        chk("w16_rst_busy", s_busy, 1'b0);
        chk("w16_rst_done", s_done, 1'b0);
        chk("w16_rst_r", s_r, '0);
        chk("w16_rst_err", s_err, 1'b0);
        chk("w16_rst_state", s_dbg_state, 2'd0);
        s_rst = 1'b1;
        req16(16'd125, 8'd17);
        req16(16'hFFFF, 8'hFF);
        req16(16'd77, 8'd0);
        for (int i = 0; i < 40; i++) begin
            req16(XS'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : PS'($urandom));
        end
        fin16 = 1'b1;
    end

    initial begin
        int n_done;
        bit seen;
        rst = 1'b0; start = 1'b0; x = '0; p = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_r", r, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        rst    = 1'b1;
        chk_en = 1'b1;

        req(64'd125, 32'd17, 32'd6, 1'b0, XW + 1, "x125_p17", 0);
        req(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, XW + 1, "max_pmax", 0);
        req(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFD, 32'd8, 1'b0, XW + 1, "max_pm3", 0);
        req(64'd5, 32'd17, 32'd5, 1'b0, XW + 1, "x5_p17", 0);
        req(64'hDEAD_BEEF_0123_4567, 32'd1, 32'd0, 1'b0, XW + 1, "p1", 0);
        req(64'h1234_5678_9ABC_DEF0, 32'd0, 32'd0, 1'b1, 1, "p0", 0);
        req(64'd125, 32'd17, 32'd6, 1'b0, XW + 1, "after_p0", 0);
        req(64'd125, 32'd17, 32'd6, 1'b0, XW + 1, "ignore_start", 12);

        // Abort mid-run with a one-cycle reset.
        start = 1'b1; x = 64'd999; p = 32'd13;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_r", r, '0);
        chk("abort_err", err, 1'b0);
        seen = 1'b0;
        repeat (XW + 5) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        req(64'd125, 32'd17, 32'd6, 1'b0, XW + 1, "after_abort", 0);

        // Start held high with x/p changing every cycle: exactly two requests fit.
        n_done = 0;
        start  = 1'b1;
        repeat (2 * (XW + 2)) begin
            x = {$urandom, $urandom};
            p = $urandom | 32'd1;
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        start = 1'b0;
        repeat (XW + 5) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("held_done_count", n_done, 2);

        for (int i = 0; i < 25; i++) req_rand();

        for (int i = 0; i < 5000 && !fin16; i++) @(negedge clk);
        chk("w16_finished", fin16, 1'b1);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
